// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the external memory port (MAR/RAM strobes plus the 16-bit bus)
// between the SAP-3 CPU and a host loader/debug requester.
//
// Normally the CPU's bus and strobes pass straight through to memory. When
// the host raises host_req, the arbiter asserts cpu_hold (ORed into the clock
// block's hlt) and waits for the CPU to reach an instruction boundary, or to
// be halted. It then performs one MAR write followed by one RAM access on the
// host's behalf. After the acknowledge, the grant lingers for RELEASE_DELAY
// cycles so that a back-to-back host request can skip the boundary wait.
// If no boundary arrives within WAIT_TIMEOUT cycles, the access is abandoned
// and acknowledged with host_err set.
//
// Parameters
//   WAIT_TIMEOUT   cycles allowed in HOLD_WAIT before the host access aborts
//   RELEASE_DELAY  cycles the grant lingers after an ack (must be >= 1)
//
// Ports
//   clk            free-running system clock (not the gated CPU clock)
//   rst            asynchronous, active-high reset
//   cpu_bus        CPU internal bus value
//   cpu_mar_we     CPU MAR write strobe
//   cpu_ram_we     CPU RAM write strobe
//   cpu_mem_oe     CPU memory read enable
//   cpu_boundary   controller is at fetch step 0
//   cpu_halted     CPU executed HLT (acts as a permanent boundary)
//   cpu_hold       stall request to the clock block
//   host_req       host access request, held until host_ack
//   host_we        1 = write, 0 = read; stable while host_req
//   host_addr      host address; stable while host_req
//   host_wdata     host write data; stable while host_req
//   host_ack       one-cycle completion pulse
//   host_err       qualifies host_ack: 1 = boundary timeout, nothing accessed
//   host_rdata     read data, valid from host_ack until the next read completes
//   mem_out        memory read data
//   mem_bus        bus to memory (MAR / RAM data)
//   mem_mar_we     MAR write strobe to memory
//   mem_ram_we     RAM write strobe to memory
//   mem_oe         memory read enable
//   host_granted   host owns the port (MAR, ACCESS, ACK, LINGER)
//   protocol_err   sticky: a CPU strobe was seen while the host owned the port
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int WAIT_TIMEOUT  = 64,
  parameter int RELEASE_DELAY = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic [15:0] cpu_bus,
  input  logic        cpu_mar_we,
  input  logic        cpu_ram_we,
  input  logic        cpu_mem_oe,
  input  logic        cpu_boundary,
  input  logic        cpu_halted,
  output logic        cpu_hold,

  input  logic        host_req,
  input  logic        host_we,
  input  logic [15:0] host_addr,
  input  logic [7:0]  host_wdata,
  output logic        host_ack,
  output logic        host_err,
  output logic [7:0]  host_rdata,

  input  logic [7:0]  mem_out,
  output logic [15:0] mem_bus,
  output logic        mem_mar_we,
  output logic        mem_ram_we,
  output logic        mem_oe,

  output logic        host_granted,
  output logic        protocol_err
);

  // Counter widths leave headroom so that the terminal values always fit.
  localparam int WW = $clog2(WAIT_TIMEOUT + 1);
  localparam int LW = $clog2(RELEASE_DELAY + 1);
  localparam logic [WW-1:0] WAIT_LAST   = WW'(WAIT_TIMEOUT - 1);
  localparam logic [LW-1:0] LINGER_LAST = LW'(RELEASE_DELAY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD_WAIT,
    S_MAR,
    S_ACCESS,
    S_ACK,
    S_LINGER,
    S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [LW-1:0]   linger_cnt_q, linger_cnt_d;
  logic [7:0]      host_rdata_q, host_rdata_d;
  logic            protocol_err_q, protocol_err_d;
  logic            cpu_hold_q, cpu_hold_d;
  logic            host_ack_q, host_ack_d;
  logic            host_err_q, host_err_d;
  logic            host_granted_q, host_granted_d;

  logic            cpu_strobe_any;
  logic            at_boundary;

  assign cpu_strobe_any = cpu_mar_we | cpu_ram_we | cpu_mem_oe;
  assign at_boundary    = cpu_boundary | cpu_halted;

  // ---------------------------------------------------------------------------
  // Next-state and datapath-register logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves one unassigned; an unassigned path would infer a latch.
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    linger_cnt_d   = linger_cnt_q;
    host_rdata_d   = host_rdata_q;
    protocol_err_d = protocol_err_q | (host_granted_q & cpu_strobe_any);

    unique case (state_q)
      S_IDLE: begin
        // A boundary seen in this same cycle is ignored: the CPU has not yet
        // been stalled, so it could move past that boundary.
        if (host_req) begin
          state_d    = S_HOLD_WAIT;
          wait_cnt_d = '0;
        end
      end

      S_HOLD_WAIT: begin
        if (at_boundary) begin
          state_d = S_MAR;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = S_ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      S_MAR: begin
        state_d = S_ACCESS;
      end

      S_ACCESS: begin
        if (!host_we) begin
          host_rdata_d = mem_out;
        end
        state_d = S_ACK;
      end

      S_ACK: begin
        state_d      = S_LINGER;
        linger_cnt_d = '0;
      end

      S_LINGER: begin
        // The CPU is still stalled, so a fresh request can go straight to MAR.
        if (host_req) begin
          state_d = S_MAR;
        end else if (linger_cnt_q == LINGER_LAST) begin
          state_d = S_IDLE;
        end else begin
          linger_cnt_d = linger_cnt_q + 1'b1;
        end
      end

      S_ERR: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status outputs are registered from the next state, so they change exactly
  // when the FSM enters a state and carry no decode glitches.
  always_comb begin
    cpu_hold_d     = 1'b0;
    host_ack_d     = 1'b0;
    host_err_d     = 1'b0;
    host_granted_d = 1'b0;

    unique case (state_d)
      S_HOLD_WAIT: cpu_hold_d = 1'b1;
      S_MAR, S_ACCESS, S_LINGER: begin
        cpu_hold_d     = 1'b1;
        host_granted_d = 1'b1;
      end
      S_ACK: begin
        cpu_hold_d     = 1'b1;
        host_granted_d = 1'b1;
        host_ack_d     = 1'b1;
      end
      S_ERR: begin
        host_ack_d = 1'b1;
        host_err_d = 1'b1;
      end
      default: begin
        cpu_hold_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so that every flop
  // samples values from before the edge, whatever order the statements run in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      wait_cnt_q     <= '0;
      linger_cnt_q   <= '0;
      host_rdata_q   <= '0;
      protocol_err_q <= 1'b0;
      cpu_hold_q     <= 1'b0;
      host_ack_q     <= 1'b0;
      host_err_q     <= 1'b0;
      host_granted_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      linger_cnt_q   <= linger_cnt_d;
      host_rdata_q   <= host_rdata_d;
      protocol_err_q <= protocol_err_d;
      cpu_hold_q     <= cpu_hold_d;
      host_ack_q     <= host_ack_d;
      host_err_q     <= host_err_d;
      host_granted_q <= host_granted_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory port mux
  // ---------------------------------------------------------------------------
  // IDLE and HOLD_WAIT pass the CPU through combinationally. The CPU keeps
  // running until it reaches a boundary. Every other state drives the port
  // from the host side, or leaves it quiet, and CPU strobes are masked.
  always_comb begin
    mem_bus    = '0;
    mem_mar_we = 1'b0;
    mem_ram_we = 1'b0;
    mem_oe     = 1'b0;

    unique case (state_q)
      S_IDLE, S_HOLD_WAIT: begin
        mem_bus    = cpu_bus;
        mem_mar_we = cpu_mar_we;
        mem_ram_we = cpu_ram_we;
        mem_oe     = cpu_mem_oe;
      end
      S_MAR: begin
        mem_bus    = host_addr;
        mem_mar_we = 1'b1;
      end
      S_ACCESS: begin
        if (host_we) begin
          mem_bus    = {8'h00, host_wdata};
          mem_ram_we = 1'b1;
        end else begin
          mem_oe = 1'b1;
        end
      end
      default: begin
        mem_bus = '0;
      end
    endcase
  end

  assign cpu_hold     = cpu_hold_q;
  assign host_ack     = host_ack_q;
  assign host_err     = host_err_q;
  assign host_rdata   = host_rdata_q;
  assign host_granted = host_granted_q;
  assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed, self-checking bench for mem_port_arbiter using the default
// parameters (WAIT_TIMEOUT = 64, RELEASE_DELAY = 4).
//
// Each "cycle" starts 2 time units after a rising edge. Inputs are applied
// then, and outputs are compared 1 time unit later, well away from the edges.
// Cycle numbers in the comments count from the cycle in which host_req is
// first presented (c0).
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic [15:0] cpu_bus;
  logic        cpu_mar_we, cpu_ram_we, cpu_mem_oe;
  logic        cpu_boundary, cpu_halted;
  logic        cpu_hold;
  logic        host_req, host_we;
  logic [15:0] host_addr;
  logic [7:0]  host_wdata;
  logic        host_ack, host_err;
  logic [7:0]  host_rdata;
  logic [7:0]  mem_out;
  logic [15:0] mem_bus;
  logic        mem_mar_we, mem_ram_we, mem_oe;
  logic        host_granted, protocol_err;

  int n_checks = 0;
  int n_errors = 0;

  logic strobe_seen, ack_seen, hold_lost, hold_seen;

  mem_port_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_bus      (cpu_bus),
    .cpu_mar_we   (cpu_mar_we),
    .cpu_ram_we   (cpu_ram_we),
    .cpu_mem_oe   (cpu_mem_oe),
    .cpu_boundary (cpu_boundary),
    .cpu_halted   (cpu_halted),
    .cpu_hold     (cpu_hold),
    .host_req     (host_req),
    .host_we      (host_we),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .host_ack     (host_ack),
    .host_err     (host_err),
    .host_rdata   (host_rdata),
    .mem_out      (mem_out),
    .mem_bus      (mem_bus),
    .mem_mar_we   (mem_mar_we),
    .mem_ram_we   (mem_ram_we),
    .mem_oe       (mem_oe),
    .host_granted (host_granted),
    .protocol_err (protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Move to the input-drive point of the next cycle.
  task automatic nc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (checks %0d, errors %0d)", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    cpu_bus = '0; cpu_mar_we = 0; cpu_ram_we = 0; cpu_mem_oe = 0;
    cpu_boundary = 0; cpu_halted = 0;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    mem_out = '0;

    // ---------------- Reset state ----------------
    #3;
    check("rst_cpu_hold",     cpu_hold,     1'b0);
    check("rst_host_ack",     host_ack,     1'b0);
    check("rst_host_err",     host_err,     1'b0);
    check("rst_host_rdata",   host_rdata,   8'h00);
    check("rst_mem_bus",      mem_bus,      16'h0000);
    check("rst_mem_mar_we",   mem_mar_we,   1'b0);
    check("rst_mem_ram_we",   mem_ram_we,   1'b0);
    check("rst_mem_oe",       mem_oe,       1'b0);
    check("rst_host_granted", host_granted, 1'b0);
    check("rst_protocol_err", protocol_err, 1'b0);
    nc(); nc();
    rst = 1'b0;

    // ---------------- Idle CPU traffic passes through ----------------
    nc();
    cpu_mar_we = 1; cpu_bus = 16'h1234; #1;
    check("idle_mar_we",   mem_mar_we, 1'b1);
    check("idle_mem_bus",  mem_bus,    16'h1234);
    check("idle_ram_we",   mem_ram_we, 1'b0);
    check("idle_no_hold",  cpu_hold,   1'b0);
    nc();
    cpu_mar_we = 0; cpu_bus = '0; #1;
    check("idle_no_hold2", cpu_hold,   1'b0);

    // ---------------- Host write 00A0 <= 5C, boundary 2 cycles after hold ----
    nc(); // c0 IDLE
    host_req = 1; host_we = 1; host_addr = 16'h00A0; host_wdata = 8'h5C; #1;
    check("wr_c0_hold", cpu_hold, 1'b0);
    nc(); // c1 HOLD_WAIT, CPU still passes through
    cpu_mar_we = 1; cpu_bus = 16'hBEEF; #1;
    check("wr_c1_hold",        cpu_hold,     1'b1);
    check("wr_c1_pass_bus",    mem_bus,      16'hBEEF);
    check("wr_c1_pass_mar",    mem_mar_we,   1'b1);
    check("wr_c1_not_granted", host_granted, 1'b0);
    nc(); // c2 HOLD_WAIT
    cpu_mar_we = 0; cpu_bus = '0; #1;
    check("wr_c2_hold",    cpu_hold,     1'b1);
    check("wr_c2_perr",    protocol_err, 1'b0);
    nc(); // c3 HOLD_WAIT, boundary
    cpu_boundary = 1; #1;
    check("wr_c3_no_mar",  mem_mar_we, 1'b0);
    nc(); // c4 MAR
    cpu_boundary = 0; #1;
    check("wr_mar_bus",     mem_bus,      16'h00A0);
    check("wr_mar_we",      mem_mar_we,   1'b1);
    check("wr_mar_ram_we",  mem_ram_we,   1'b0);
    check("wr_mar_granted", host_granted, 1'b1);
    nc(); // c5 ACCESS
    #1;
    check("wr_acc_bus",    mem_bus,    16'h005C);
    check("wr_acc_ram_we", mem_ram_we, 1'b1);
    check("wr_acc_mar_we", mem_mar_we, 1'b0);
    check("wr_acc_oe",     mem_oe,     1'b0);
    check("wr_acc_no_ack", host_ack,   1'b0);
    nc(); // c6 ACK
    #1;
    check("wr_ack",        host_ack,   1'b1);
    check("wr_ack_err",    host_err,   1'b0);
    check("wr_ack_hold",   cpu_hold,   1'b1);
    check("wr_ack_ram_we", mem_ram_we, 1'b0);
    check("wr_rdata_kept", host_rdata, 8'h00);
    nc(); // c7 LINGER
    host_req = 0; #1;
    check("wr_lin_ack",     host_ack,     1'b0);
    check("wr_lin_hold",    cpu_hold,     1'b1);
    check("wr_lin_granted", host_granted, 1'b1);
    nc(); nc(); nc(); // c10 last LINGER cycle
    #1;
    check("wr_lin_last_hold", cpu_hold, 1'b1);
    nc(); // c11 IDLE
    #1;
    check("wr_release_hold",    cpu_hold,     1'b0);
    check("wr_release_granted", host_granted, 1'b0);

    // ---------------- Host read 0010 with cpu_halted ----------------
    nc(); // c0 IDLE (halted in this cycle must not shortcut the wait)
    host_req = 1; host_we = 0; host_addr = 16'h0010; cpu_halted = 1; mem_out = 8'hE7; #1;
    check("rd_c0_hold", cpu_hold, 1'b0);
    nc(); // c1 HOLD_WAIT
    #1;
    check("rd_c1_hold",        cpu_hold,     1'b1);
    check("rd_c1_not_granted", host_granted, 1'b0);
    nc(); // c2 MAR
    #1;
    check("rd_mar_bus", mem_bus,    16'h0010);
    check("rd_mar_we",  mem_mar_we, 1'b1);
    nc(); // c3 ACCESS
    #1;
    check("rd_acc_oe",     mem_oe,     1'b1);
    check("rd_acc_bus",    mem_bus,    16'h0000);
    check("rd_acc_ram_we", mem_ram_we, 1'b0);
    check("rd_acc_no_ack", host_ack,   1'b0);
    nc(); // c4 ACK
    mem_out = 8'h00; #1;
    check("rd_ack",       host_ack,   1'b1);
    check("rd_ack_err",   host_err,   1'b0);
    check("rd_rdata",     host_rdata, 8'hE7);
    nc(); // c5 LINGER
    host_req = 0; cpu_halted = 0; #1;
    check("rd_rdata_held", host_rdata, 8'hE7);
    repeat (4) nc(); // c9 IDLE
    #1;
    check("rd_release_hold", cpu_hold, 1'b0);

    // ---------------- Boundary timeout ----------------
    nc(); // c0 IDLE
    host_req = 1; host_we = 0; host_addr = 16'h0033; #1;
    strobe_seen = 0; ack_seen = 0; hold_lost = 0;
    for (int i = 1; i <= 64; i++) begin // c1..c64 HOLD_WAIT
      nc();
      #1;
      if (mem_mar_we | mem_ram_we | mem_oe) strobe_seen = 1;
      if (host_ack) ack_seen = 1;
      if (!cpu_hold) hold_lost = 1;
    end
    check("to_no_strobe",  strobe_seen, 1'b0);
    check("to_no_ack",     ack_seen,    1'b0);
    check("to_hold_kept",  hold_lost,   1'b0);
    nc(); // c65 ERR
    #1;
    check("to_ack",        host_ack,   1'b1);
    check("to_err",        host_err,   1'b1);
    check("to_hold_drop",  cpu_hold,   1'b0);
    check("to_rdata_kept", host_rdata, 8'hE7);
    check("to_no_mar",     mem_mar_we, 1'b0);
    nc(); // c66 IDLE
    host_req = 0; #1;
    check("to_ack_pulse", host_ack, 1'b0);
    check("to_err_clear", host_err, 1'b0);
    check("to_idle_hold", cpu_hold, 1'b0);

    // ---------------- Back-to-back writes, then reset in ACCESS ----------
    hold_lost = 0;
    nc(); // c0 IDLE
    host_req = 1; host_we = 1; host_addr = 16'h0100; host_wdata = 8'h11; #1;
    nc(); // c1 HOLD_WAIT
    cpu_boundary = 1; #1;
    if (!cpu_hold) hold_lost = 1;
    nc(); // c2 MAR
    cpu_boundary = 0; #1;
    if (!cpu_hold) hold_lost = 1;
    check("b2b1_mar_bus", mem_bus, 16'h0100);
    nc(); // c3 ACCESS
    #1;
    if (!cpu_hold) hold_lost = 1;
    check("b2b1_acc_bus", mem_bus, 16'h0011);
    nc(); // c4 ACK
    #1;
    if (!cpu_hold) hold_lost = 1;
    check("b2b1_ack", host_ack, 1'b1);
    nc(); // c5 LINGER
    host_req = 0; #1;
    if (!cpu_hold) hold_lost = 1;
    nc(); // c6 LINGER, second request
    host_req = 1; host_addr = 16'h0101; host_wdata = 8'h22; #1;
    if (!cpu_hold) hold_lost = 1;
    nc(); // c7 MAR directly
    #1;
    if (!cpu_hold) hold_lost = 1;
    check("b2b2_mar_bus", mem_bus,    16'h0101);
    check("b2b2_mar_we",  mem_mar_we, 1'b1);
    nc(); // c8 ACCESS
    #1;
    if (!cpu_hold) hold_lost = 1;
    check("b2b2_acc_bus",    mem_bus,    16'h0022);
    check("b2b2_acc_ram_we", mem_ram_we, 1'b1);
    nc(); // c9 ACK
    #1;
    if (!cpu_hold) hold_lost = 1;
    check("b2b2_ack",       host_ack,  1'b1);
    check("b2b_hold_kept",  hold_lost, 1'b0);
    nc(); // c10 LINGER
    host_req = 0; #1;
    nc(); // c11 LINGER, third request
    host_req = 1; host_addr = 16'h0200; host_wdata = 8'h33; #1;
    nc(); // c12 MAR
    #1;
    check("b2b3_mar_we", mem_mar_we, 1'b1);
    nc(); // c13 ACCESS, reset lands mid-cycle
    #1;
    check("b2b3_acc_ram_we", mem_ram_we, 1'b1);
    rst = 1; host_req = 0; #1;
    check("rsta_hold",    cpu_hold,     1'b0);
    check("rsta_ram_we",  mem_ram_we,   1'b0);
    check("rsta_mar_we",  mem_mar_we,   1'b0);
    check("rsta_bus",     mem_bus,      16'h0000);
    check("rsta_granted", host_granted, 1'b0);
    check("rsta_ack",     host_ack,     1'b0);
    check("rsta_rdata",   host_rdata,   8'h00);
    nc(); nc();
    rst = 0;
    ack_seen = 0; hold_seen = 0;
    for (int i = 0; i < 6; i++) begin
      nc();
      #1;
      if (host_ack) ack_seen = 1;
      if (cpu_hold) hold_seen = 1;
    end
    check("rsta_no_ack_after",  ack_seen,  1'b0);
    check("rsta_no_hold_after", hold_seen, 1'b0);

    // ---------------- CPU strobe while granted ----------------
    nc(); // c0 IDLE
    host_req = 1; host_we = 0; host_addr = 16'h0044; mem_out = 8'h3A; cpu_boundary = 1; #1;
    nc(); // c1 HOLD_WAIT, boundary present
    #1;
    check("pe_c1_not_granted", host_granted, 1'b0);
    nc(); // c2 MAR
    cpu_boundary = 0; cpu_ram_we = 1; #1;
    check("pe_mar_ram_masked", mem_ram_we,   1'b0);
    check("pe_mar_we",         mem_mar_we,   1'b1);
    check("pe_not_yet",        protocol_err, 1'b0);
    nc(); // c3 ACCESS
    cpu_ram_we = 0; #1;
    check("pe_set",    protocol_err, 1'b1);
    check("pe_acc_oe", mem_oe,       1'b1);
    nc(); // c4 ACK
    #1;
    check("pe_rdata", host_rdata, 8'h3A);
    nc(); // c5 LINGER
    host_req = 0;
    repeat (4) nc(); // c9 IDLE
    #1;
    check("pe_idle_hold", cpu_hold,     1'b0);
    check("pe_sticky",    protocol_err, 1'b1);
    rst = 1; #1;
    check("pe_cleared", protocol_err, 1'b0);
    nc();
    rst = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
